// File: rtl/hwpe_ctrl_regfile_bist.sv
// ============================================================================
// Module   : hwpe_ctrl_regfile_bist
// Purpose  : March-style BIST controller for a single-port register file.
//            Runs M0 (up, w0), M1 (up, r0 w1), M2 (down, r1 w0), M3 (down, r0),
//            compares read data one cycle after each read, and reports a
//            sticky fail flag with the address of the first mismatch.
// Ports    : clk, rst_n (async, active low), clear (sync soft clear),
//            start        - run request, honoured only in IDLE/DONE
//            done         - high while in DONE
//            fail         - sticky mismatch flag
//            fail_addr    - address of the first mismatch of the run
//            BIST         - test-mode select, high while the march is active
//            CSN_T/WEN_T  - active-low chip select / write enable
//            A_T/D_T/BE_T - test address, write data, byte enables
//            Q_T          - read data, valid one cycle after a read
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hwpe_ctrl_regfile_bist #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_BYTE   = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  start,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic                  BIST,
  output logic                  CSN_T,
  output logic                  WEN_T,
  output logic [ADDR_WIDTH-1:0] A_T,
  output logic [DATA_WIDTH-1:0] D_T,
  output logic [NUM_BYTE-1:0]   BE_T,
  input  logic [DATA_WIDTH-1:0] Q_T
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    M0_W  = 4'd1,
    M1_R  = 4'd2,
    M1_W  = 4'd3,
    M2_R  = 4'd4,
    M2_W  = 4'd5,
    M3_R  = 4'd6,
    DRAIN = 4'd7,
    DONE  = 4'd8
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    rd_pend_q, rd_pend_d;
  logic [DATA_WIDTH-1:0]   exp_q, exp_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                    fail_q, fail_d;
  logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
  logic                    mismatch;
  logic                    last_up, last_dn;

  assign mismatch = rd_pend_q && (Q_T != exp_q);
  assign last_up  = (addr_q == ADDR_MAX);
  assign last_dn  = (addr_q == '0);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_pend_d   = 1'b0;
    exp_d       = exp_q;
    rd_addr_d   = rd_addr_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    CSN_T       = 1'b1;
    WEN_T       = 1'b1;
    A_T         = '0;
    D_T         = '0;

    // Compare the read issued last cycle; only the first failure records an address.
    if (mismatch) begin
      fail_d = 1'b1;
      if (!fail_q) fail_addr_d = rd_addr_q;
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = M0_W;
          addr_d      = '0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
        end
      end
      M0_W: begin
        CSN_T  = 1'b0;
        WEN_T  = 1'b0;
        A_T    = addr_q;
        addr_d = addr_q + 1'b1;   // wraps to 0, the start of M1
        if (last_up) state_d = M1_R;
      end
      M1_R: begin
        CSN_T     = 1'b0;
        A_T       = addr_q;
        rd_pend_d = 1'b1;
        exp_d     = '0;
        rd_addr_d = addr_q;
        state_d   = M1_W;
      end
      M1_W: begin
        CSN_T  = 1'b0;
        WEN_T  = 1'b0;
        A_T    = addr_q;
        D_T    = '1;
        if (last_up) begin
          state_d = M2_R;
          addr_d  = ADDR_MAX;
        end else begin
          state_d = M1_R;
          addr_d  = addr_q + 1'b1;
        end
      end
      M2_R: begin
        CSN_T     = 1'b0;
        A_T       = addr_q;
        rd_pend_d = 1'b1;
        exp_d     = '1;
        rd_addr_d = addr_q;
        state_d   = M2_W;
      end
      M2_W: begin
        CSN_T  = 1'b0;
        WEN_T  = 1'b0;
        A_T    = addr_q;
        addr_d = addr_q - 1'b1;   // wraps to the top address, the start of M3
        state_d = last_dn ? M3_R : M2_R;
      end
      M3_R: begin
        CSN_T     = 1'b0;
        A_T       = addr_q;
        rd_pend_d = 1'b1;
        exp_d     = '0;
        rd_addr_d = addr_q;
        addr_d    = addr_q - 1'b1;
        if (last_dn) state_d = DRAIN;
      end
      DRAIN: begin
        // No access; the final M3 read is compared in this cycle.
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (clear) begin
      state_d     = IDLE;
      addr_d      = '0;
      rd_pend_d   = 1'b0;
      fail_d      = 1'b0;
      fail_addr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rd_pend_q   <= 1'b0;
      exp_q       <= '0;
      rd_addr_q   <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_pend_q   <= rd_pend_d;
      exp_q       <= exp_d;
      rd_addr_q   <= rd_addr_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
    end
  end

  assign done      = (state_q == DONE);
  assign BIST      = (state_q != IDLE) && (state_q != DONE);
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign BE_T      = '1;

endmodule

`default_nettype wire

// File: tb/tb_hwpe_ctrl_regfile_bist.sv
// ============================================================================
// Module   : tb_hwpe_ctrl_regfile_bist
// Purpose  : Self-checking bench for hwpe_ctrl_regfile_bist with a faulty
//            register-file model and a march-algorithm reference.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hwpe_ctrl_regfile_bist;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NB = DW/8;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          done, fail, BIST, CSN_T, WEN_T;
  logic [AW-1:0] fail_addr, A_T;
  logic [DW-1:0] D_T, Q_T;
  logic [NB-1:0] BE_T;

  int n_total = 0;
  int n_bad   = 0;

  hwpe_ctrl_regfile_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
    .done(done), .fail(fail), .fail_addr(fail_addr), .BIST(BIST),
    .CSN_T(CSN_T), .WEN_T(WEN_T), .A_T(A_T), .D_T(D_T), .BE_T(BE_T), .Q_T(Q_T)
  );

  always #5 clk = ~clk;

  // Register-file model with stuck-at cells, applied on read.
  logic [DW-1:0] sa0 [N];
  logic [DW-1:0] sa1 [N];
  logic [DW-1:0] mem [N];
  logic [DW-1:0] q_r = '0;
  assign Q_T = q_r;

  always @(posedge clk) begin
    if (!CSN_T) begin
      if (!WEN_T) mem[A_T] <= D_T;
      else        q_r <= (mem[A_T] & ~sa0[A_T]) | sa1[A_T];
    end
  end

  // Reference: march operation list and the first mismatching operation.
  typedef struct {
    bit            wr;
    int            a;
    logic [DW-1:0] d;
    logic [DW-1:0] e;
  } op_t;

  op_t op_q[$];
  int  mm_idx;
  int  mm_addr;

  function automatic op_t mk(bit wr, int a, logic [DW-1:0] d, logic [DW-1:0] e);
    op_t o;
    o.wr = wr; o.a = a; o.d = d; o.e = e;
    return o;
  endfunction

  task automatic build_ref();
    logic [DW-1:0] m [N];
    logic [DW-1:0] got;
    logic [DW-1:0] ones;
    ones = '1;
    op_q.delete();
    for (int a = 0; a < N; a++) op_q.push_back(mk(1'b1, a, '0, '0));
    for (int a = 0; a < N; a++) begin
      op_q.push_back(mk(1'b0, a, '0, '0));
      op_q.push_back(mk(1'b1, a, ones, '0));
    end
    for (int a = N-1; a >= 0; a--) begin
      op_q.push_back(mk(1'b0, a, '0, ones));
      op_q.push_back(mk(1'b1, a, '0, '0));
    end
    for (int a = N-1; a >= 0; a--) op_q.push_back(mk(1'b0, a, '0, '0));
    mm_idx = -1;
    mm_addr = 0;
    for (int i = 0; i < op_q.size(); i++) begin
      if (op_q[i].wr) m[op_q[i].a] = op_q[i].d;
      else begin
        got = (m[op_q[i].a] & ~sa0[op_q[i].a]) | sa1[op_q[i].a];
        if (got != op_q[i].e && mm_idx < 0) begin
          mm_idx  = i;
          mm_addr = op_q[i].a;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(logic dn, logic bi, logic cs, logic we,
                                     logic [AW-1:0] a, logic [DW-1:0] d,
                                     logic [NB-1:0] be, logic fl, logic [AW-1:0] fa);
    return {13'd0, dn, bi, cs, we, a, d, be, fl, fa};
  endfunction

  // Observed outputs; address/data masked where the access does not use them.
  function automatic logic [63:0] obs(bit raw);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = (raw || !CSN_T) ? A_T : '0;
    d = (raw || (!CSN_T && !WEN_T)) ? D_T : '0;
    return pk(done, BIST, CSN_T, WEN_T, a, d, BE_T, fail, fail_addr);
  endfunction

  task automatic clear_faults();
    for (int a = 0; a < N; a++) begin
      sa0[a] = '0;
      sa1[a] = '0;
    end
  endtask

  // Called at a negedge in IDLE or DONE. Starts a run and checks every cycle.
  // abort_kind: 0 none, 1 clear, 2 reset at cycle abort_cyc.
  task automatic run(input string nm, input int hold, input int pulse,
                     input int abort_cyc, input int abort_kind);
    logic [63:0] e;
    op_t         o;
    bit          fl;
    build_ref();
    start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 6*N+2; k++) begin
      fl = (mm_idx >= 0) && (k >= mm_idx + 3);
      if (k <= 6*N) begin
        o = op_q[k-1];
        e = pk(1'b0, 1'b1, 1'b0, ~o.wr, o.a[AW-1:0], o.wr ? o.d : '0, '1,
               fl, fl ? mm_addr[AW-1:0] : '0);
      end else begin
        e = pk(k == 6*N+2, k == 6*N+1, 1'b1, 1'b1, '0, '0, '1,
               fl, fl ? mm_addr[AW-1:0] : '0);
      end
      check($sformatf("%s c%0d", nm, k), obs(1'b0), e);
      if (k == abort_cyc) begin
        start = 1'b0;
        if (abort_kind == 1) begin
          clear = 1'b1;
          @(negedge clk);
          clear = 1'b0;
          check($sformatf("%s after_clear", nm), obs(1'b0),
                pk(1'b0, 1'b0, 1'b1, 1'b1, '0, '0, '1, 1'b0, '0));
        end else begin
          #1 rst_n = 1'b0;
          #1 check($sformatf("%s in_reset", nm), obs(1'b1),
                   pk(1'b0, 1'b0, 1'b1, 1'b1, '0, '0, '1, 1'b0, '0));
          @(negedge clk);
          rst_n = 1'b1;
        end
        return;
      end
      start = (k < hold) || (k == pulse);
      if (k < 6*N+2) @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < N; a++) mem[a] = $urandom;
    clear_faults();
    repeat (2) @(negedge clk);
    check("reset_outputs", obs(1'b1), pk(1'b0, 1'b0, 1'b1, 1'b1, '0, '0, '1, 1'b0, '0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", obs(1'b1), pk(1'b0, 1'b0, 1'b1, 1'b1, '0, '0, '1, 1'b0, '0));

    run("clean", 1, 0, 0, 0);

    sa0[17] = 32'h0000_0008;
    run("stuck17", 1, 0, 0, 0);
    clear_faults();

    // Started from DONE with fail set and start held: fail must clear.
    run("restart", 4, 0, 0, 0);

    sa1[5] = 32'h0000_0001;
    sa1[9] = 32'h0001_0000;
    run("two_fault", 1, 0, 0, 0);
    clear_faults();

    run("pulse50", 1, 50, 0, 0);

    sa1[2] = 32'h8000_0000;
    run("clear100", 1, 0, 100, 1);
    clear_faults();
    run("after_clear", 1, 0, 0, 0);

    run("reset120", 1, 0, 120, 2);
    run("after_reset", 1, 0, 0, 0);

    for (int r = 0; r < 4; r++) begin
      int nf;
      int fa;
      int fb;
      clear_faults();
      nf = $urandom_range(0, 2);
      for (int f = 0; f < nf; f++) begin
        fa = $urandom_range(0, N-1);
        fb = $urandom_range(0, DW-1);
        if ($urandom_range(0, 1) == 1) sa1[fa][fb] = 1'b1;
        else                           sa0[fa][fb] = 1'b1;
      end
      run($sformatf("rand%0d", r), 1 + $urandom_range(0, 3),
          $urandom_range(2, 190), 0, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
